// File: rtl/tile_blitter_if.sv
// tile_blitter_if: command handshake and image RAM write bus of the tile blitter.
//   cmd_valid / cmd_ready    command handshake, accepted when both are high
//   cmd_x, cmd_y             tile column (0..39) and row (0..29)
//   cmd_color, cmd_border    fill color and outline request
//   img_addr/img_data/wren   image RAM write port (row-major pixel address)
//   busy, done, err          status: busy while drawing, done/err one-cycle pulses
// master = command issuer, slave = the blitter.
interface tile_blitter_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [5:0]  cmd_x;
   logic [4:0]  cmd_y;
   logic [7:0]  cmd_color;
   logic        cmd_border;
   logic [18:0] img_addr;
   logic [7:0]  img_data;
   logic        img_wren;
   logic        busy;
   logic        done;
   logic        err;

   modport master (
      output cmd_valid, cmd_x, cmd_y, cmd_color, cmd_border,
      input  cmd_ready, img_addr, img_data, img_wren, busy, done, err
   );

   modport slave (
      input  cmd_valid, cmd_x, cmd_y, cmd_color, cmd_border,
      output cmd_ready, img_addr, img_data, img_wren, busy, done, err
   );
endinterface

// File: rtl/tile_blitter.sv
// tile_blitter: paints one 16x16 tile of the 640x480 8bpp framebuffer per command,
// one pixel per cycle, optionally with a 1-pixel outline in BORDER_COLOR.
//   clock  rising-edge system clock
//   reset  synchronous, active-high
//   bus    tile_blitter_if.slave: command handshake in, image RAM write port and
//          status (busy, done, err) out; every output is registered.
module tile_blitter #(
   parameter int unsigned SCREEN_W     = 640,
   parameter int unsigned TILE         = 16,
   parameter int unsigned COLS         = 40,
   parameter int unsigned ROWS         = 30,
   parameter logic [7:0]  BORDER_COLOR = 8'hFF
) (
   input logic           clock,
   input logic           reset,
   tile_blitter_if.slave bus
);

   localparam int unsigned CW = $clog2(TILE);

   localparam logic [CW-1:0] LAST      = CW'(TILE - 1);
   localparam logic [5:0]    COLS_V    = 6'(COLS);
   localparam logic [4:0]    ROWS_V    = 5'(ROWS);
   localparam logic [18:0]   TILE_ROW  = 19'(TILE * SCREEN_W);
   localparam logic [18:0]   TILE_W    = 19'(TILE);
   // Jump from the last pixel of one tile row to the first pixel of the next.
   localparam logic [18:0]   ROW_STEP  = 19'(SCREEN_W - TILE + 1);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_FILL   = 2'd1;
   localparam logic [1:0] ST_DONE   = 2'd2;
   localparam logic [1:0] ST_REJECT = 2'd3;

   logic [1:0]    state_q, state_d;
   logic [CW-1:0] r_q, r_d, c_q, c_d;
   logic [7:0]    color_q, color_d;
   logic          border_q, border_d;
   logic [18:0]   addr_q, addr_d;
   logic [7:0]    data_q, data_d;
   logic          wren_q, wren_d;
   logic          ready_q, ready_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          err_q, err_d;

   function automatic logic on_edge(input logic [CW-1:0] r, input logic [CW-1:0] c);
      return (r == '0) || (r == LAST) || (c == '0) || (c == LAST);
   endfunction

   always_comb begin
      state_d  = state_q;
      r_d      = r_q;
      c_d      = c_q;
      color_d  = color_q;
      border_d = border_q;
      addr_d   = addr_q;
      data_d   = data_q;
      wren_d   = 1'b0;
      ready_d  = 1'b0;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      err_d    = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            ready_d = 1'b1;
            if (bus.cmd_valid) begin
               ready_d = 1'b0;
               if (bus.cmd_x >= COLS_V || bus.cmd_y >= ROWS_V) begin
                  state_d = ST_REJECT;
                  err_d   = 1'b1;
               end else begin
                  // x/y only feed the base address, so only color/border are kept.
                  state_d  = ST_FILL;
                  color_d  = bus.cmd_color;
                  border_d = bus.cmd_border;
                  r_d      = '0;
                  c_d      = '0;
                  addr_d   = 19'(bus.cmd_y) * TILE_ROW + 19'(bus.cmd_x) * TILE_W;
                  // Pixel (0,0) is always on the outline.
                  data_d   = bus.cmd_border ? BORDER_COLOR : bus.cmd_color;
                  wren_d   = 1'b1;
                  busy_d   = 1'b1;
               end
            end
         end
         ST_FILL: begin
            busy_d = 1'b1;
            if (r_q == LAST && c_q == LAST) begin
               state_d = ST_DONE;
               done_d  = 1'b1;
            end else begin
               wren_d = 1'b1;
               if (c_q == LAST) begin
                  c_d    = '0;
                  r_d    = r_q + CW'(1);
                  addr_d = addr_q + ROW_STEP;
               end else begin
                  c_d    = c_q + CW'(1);
                  addr_d = addr_q + 19'd1;
               end
               data_d = (border_q && on_edge(r_d, c_d)) ? BORDER_COLOR : color_q;
            end
         end
         ST_DONE, ST_REJECT: begin
            state_d = ST_IDLE;
            ready_d = 1'b1;
         end
         default: begin
            state_d = ST_IDLE;
            ready_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         r_q      <= '0;
         c_q      <= '0;
         color_q  <= '0;
         border_q <= 1'b0;
         addr_q   <= '0;
         data_q   <= '0;
         wren_q   <= 1'b0;
         ready_q  <= 1'b1;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         r_q      <= r_d;
         c_q      <= c_d;
         color_q  <= color_d;
         border_q <= border_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
         wren_q   <= wren_d;
         ready_q  <= ready_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         err_q    <= err_d;
      end
   end

   assign bus.cmd_ready = ready_q;
   assign bus.img_addr  = addr_q;
   assign bus.img_data  = data_q;
   assign bus.img_wren  = wren_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.err       = err_q;

endmodule

// File: doc/tile_blitter.md
# tile_blitter

Hardware tile writer for the Tetris framebuffer. Accepts one "paint tile" command at a time and fills a 16x16-pixel cell of the 640x480, 8-bit-per-pixel image RAM through its processor-side write port, one pixel per cycle. It is the writer counterpart of the VGA scan-out reader on the other image RAM port, and it offloads cell drawing from the processor's software pixel loop.

## Interface
- SCREEN_W, 640, framebuffer width in pixels (row pitch)
- TILE, 16, tile edge in pixels
- COLS, 40, number of tile columns
- ROWS, 30, number of tile rows
- BORDER_COLOR, 8'hFF, color of the 1-pixel tile outline when a border is requested
- clock  in  1  system clock; all logic is on its rising edge
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command; high only in IDLE
- cmd_x  in  6  tile column, 0..COLS-1
- cmd_y  in  5  tile row, 0..ROWS-1
- cmd_color  in  8  fill color
- cmd_border  in  1  1 = draw the outer ring of pixels in BORDER_COLOR
- img_addr  out  19  image RAM address, row-major: y*SCREEN_W + x
- img_data  out  8  pixel write data
- img_wren  out  1  image RAM write enable
- busy  out  1  high in FILL and DONE
- done  out  1  one-cycle pulse after the last pixel write
- err  out  1  one-cycle pulse when a command is out of range

## Operation
- States: IDLE, FILL, DONE, REJECT.
- IDLE: cmd_ready=1. A command is accepted on an edge where cmd_valid and cmd_ready are both 1. At that point x, y, color and border are latched. Input changes after acceptance are ignored.
- On acceptance, if cmd_x>=COLS or cmd_y>=ROWS, go to REJECT. Otherwise compute base = cmd_y*TILE*SCREEN_W + cmd_x*TILE and go to FILL.
- REJECT: lasts 1 cycle. err=1, no writes. Then return to IDLE.
- FILL: uses row counter r (0..15) and column counter c (0..15), column-fastest order. One write per cycle:
  - img_addr = base + r*SCREEN_W + c, produced incrementally: +1 within a row, +(SCREEN_W-TILE+1) at the end of a row.
  - img_data = BORDER_COLOR if border && (r==0 || r==15 || c==0 || c==15); otherwise color.
  - After pixel (15,15), go to DONE.
- DONE: lasts 1 cycle. done=1, img_wren=0. Then return to IDLE.
- All outputs are registered.
- Widths: the maximum address is 29*10240 + 15*640 + 39*16 + 15 = 307199, which fits in 19 bits. The address is held in a 19-bit register with no overflow in any legal case.
- Reset values: state IDLE, cmd_ready=1, img_wren=0, img_addr=0, img_data=0, busy=0, done=0, err=0.
- Reset mid-FILL: on the next edge, state returns to IDLE and img_wren=0. The partially drawn tile is left in RAM as is. No done or err pulse is produced.
- cmd_valid asserted while not in IDLE is ignored; it is accepted once the block returns to IDLE.

## Timing
- Let cycle 0 be the accepting edge.
- Cycles 1..256: img_wren=1 with one pixel per cycle. Cycle 1 carries pixel (0,0), cycle 256 carries pixel (15,15).
- Cycle 257: done=1, busy=1, img_wren=0.
- Cycle 258: IDLE with cmd_ready=1. The earliest next acceptance is at the cycle-258 edge, giving 258 cycles per tile.
- Rejected command: err=1 in cycle 1, cmd_ready=1 again in cycle 2.
- busy=1 throughout cycles 1..257 for a valid command. busy stays 0 for a rejected command.
- Port A of the image RAM is clocked on ~clock, so address and data registered on the rising edge are sampled half a cycle later. No extra wait states are inserted.

## Test plan
- Reset: hold reset for 3 cycles with cmd_valid=1 -> no acceptance and all outputs at their reset values. After release, cmd_ready=1 in the first cycle.
- x=0, y=0, color=0x1C, border=0 -> exactly 256 writes to addresses 0..15, 640..655, ..., 9600..9615, all with data 0x1C. done pulses at cycle 257.
- x=39, y=29, color=0x03, border=1 -> first address 297584, last address 307199. All of row 0 and row 15 are 0xFF. Row 1 has col 0 = 0xFF, cols 1..14 = 0x03, col 15 = 0xFF.
- x=40, y=0 (and separately x=0, y=30) -> err high for cycle 1 only, img_wren never asserted, cmd_ready=1 at cycle 2.
- Assert reset at cycle 100 of a fill -> img_wren=0 from the next cycle and no done pulse. A following command at x=1, y=1 starts at address 10256 and completes normally.
- cmd_valid held high with inputs changing during the fill -> second command accepted exactly at cycle 258. The data of the first tile is unaffected by the mid-fill input changes.
